led_blink_pio: RTL and testbench

//  Avalon-MM slave output port: the HPS writes LED state over the lightweight bridge.
//  Per-bit hardware blink with a programmable half-period counter, so software need not toggle LEDs.

---
 rtl/led_blink_pio.sv | 109 ++++++++++
 tb/tb_led_blink_pio.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_pio.sv
// Purpose : memory-mapped LED output port with per-bit hardware blink driven by a half-period timer.
// Latency : register writes reach led_out one clk after the write edge; readdata is registered (latency 1).
// Backpr. : none; writes always accepted in one cycle, no waitrequest.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous, active-low reset
//   address    word address (0 DATA, 1 MASK, 2 PERIOD, 3 TOGGLE/phase)
//   write      single-cycle write strobe
//   writedata  write data; only [WIDTH-1:0] used except for PERIOD
//   readdata   registered read data of the addressed register
//   led_out    registered LED drive, 1 = on
module led_blink_pio #(
    parameter int          WIDTH      = 10,
    parameter logic [31:0] PERIOD_RST = 32'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] led_out
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_TOGGLE = 2'd3;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [31:0]      period_q;
    logic [31:0]      cnt_q;
    logic             phase_q;

    logic             wr_data;
    logic             wr_mask;
    logic             wr_period;
    logic             wr_toggle;
    logic [31:0]      rd_nxt;

    assign wr_data   = write && (address == ADDR_DATA);
    assign wr_mask   = write && (address == ADDR_MASK);
    assign wr_period = write && (address == ADDR_PERIOD);
    assign wr_toggle = write && (address == ADDR_TOGGLE);

    // DATA and MASK registers; TOGGLE flips DATA bits in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            mask_q <= '0;
        end else begin
            if (wr_data)
                data_q <= writedata[WIDTH-1:0];
            else if (wr_toggle)
                data_q <= data_q ^ writedata[WIDTH-1:0];
            if (wr_mask)
                mask_q <= writedata[WIDTH-1:0];
        end
    end

    // Half-period timer. A PERIOD write restarts the timer from a known
    // state, which also means a smaller PERIOD can never be overrun by cnt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= PERIOD_RST;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else if (wr_period) begin
            period_q <= writedata;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else if (period_q == 32'd0) begin
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else if (cnt_q == period_q - 32'd1) begin
            cnt_q    <= '0;
            phase_q  <= ~phase_q;
        end else begin
            cnt_q    <= cnt_q + 32'd1;
        end
    end

    // Read mux over pre-edge register values; narrow registers zero-extend.
    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_DATA:   rd_nxt[WIDTH-1:0] = data_q;
            ADDR_MASK:   rd_nxt[WIDTH-1:0] = mask_q;
            ADDR_PERIOD: rd_nxt            = period_q;
            ADDR_TOGGLE: rd_nxt[0]         = phase_q;
            default:     rd_nxt            = '0;
        endcase
    end

    // Outputs are registered from pre-edge state, so a register write
    // shows up on led_out one edge after it is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            led_out  <= '0;
        end else begin
            readdata <= rd_nxt;
            led_out  <= data_q ^ (mask_q & {WIDTH{phase_q}});
        end
    end

endmodule

// File: tb/tb_led_blink_pio.sv
// Purpose : self-checking bench for led_blink_pio (table of register-level vectors plus reset sequences).
// Latency : each vector is one clk; expectations are the outputs registered at that edge.
// Backpr. : not applicable; the DUT never stalls.
module tb_led_blink_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  led_out;

    led_blink_pio #(.WIDTH(10), .PERIOD_RST(32'd0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .led_out   (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [9:0]  exp_led;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        int          tag;
        logic [9:0]  led;
        logic [31:0] rd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic wr, input logic [1:0] addr, input logic [31:0] wd,
                       input logic [9:0] exp_led, input logic [31:0] exp_rd);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wd = wd; v.exp_led = exp_led; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endtask

    task automatic check_led(input string name, input int tag, input logic [9:0] exp);
        checks++;
        if (led_out !== exp) begin
            errors++;
            $display("FAIL %s[%0d] led_out got 0x%03h want 0x%03h", name, tag, led_out, exp);
        end
    endtask

    task automatic check_rd(input string name, input int tag, input logic [31:0] exp);
        checks++;
        if (readdata !== exp) begin
            errors++;
            $display("FAIL %s[%0d] readdata got 0x%08h want 0x%08h", name, tag, readdata, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, queue the expectation,
    // then compare just after the rising edge that registers the outputs.
    task automatic apply(input string name, input int tag, input logic wr, input logic [1:0] addr,
                         input logic [31:0] wd, input logic [9:0] exp_led, input logic [31:0] exp_rd);
        exp_t e;
        @(negedge clk);
        write = wr; address = addr; writedata = wd;
        e.tag = tag; e.led = exp_led; e.rd = exp_rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s[%0d] scoreboard empty", name, tag);
        end else begin
            e = sb.pop_front();
            check_led(name, e.tag, e.led);
            check_rd(name, e.tag, e.rd);
        end
        write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; write = 1'b0; address = 2'd0; writedata = '0;

        // Static writes, including ignored upper data bits.
        add(0, 3, 0, 10'h000, 32'h0);
        add(0, 0, 0, 10'h000, 32'h0);
        add(1, 0, 32'h2A5, 10'h000, 32'h0);
        add(0, 0, 0, 10'h2A5, 32'h2A5);
        add(0, 1, 0, 10'h2A5, 32'h0);
        add(1, 0, 32'hFFFFF001, 10'h2A5, 32'h2A5);
        add(0, 0, 0, 10'h001, 32'h001);
        add(1, 1, 32'h3, 10'h001, 32'h0);
        add(0, 1, 0, 10'h001, 32'h3);
        // PERIOD=4: phase flips every 4 edges, led lags phase by one edge.
        add(1, 2, 32'd4, 10'h001, 32'h0);
        add(0, 2, 0, 10'h001, 32'd4);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        // PERIOD write on the edge where the timer would wrap: phase stays 0.
        add(1, 2, 32'd3, 10'h001, 32'd4);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h001, 32'h0);
        // Back to PERIOD=4, reach cnt=3/phase=1, then lower PERIOD to 2.
        add(1, 2, 32'd4, 10'h001, 32'd3);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h002, 32'h1);
        add(1, 2, 32'd2, 10'h002, 32'd4);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h002, 32'h1);
        add(0, 3, 0, 10'h001, 32'h0);
        // PERIOD=0 stops blinking.
        add(1, 2, 32'd0, 10'h001, 32'd2);
        add(0, 2, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        add(0, 3, 0, 10'h001, 32'h0);
        // TOGGLE with MASK=0.
        add(1, 0, 32'h0F0, 10'h001, 32'h001);
        add(1, 1, 32'h0, 10'h0F0, 32'h3);
        add(1, 3, 32'h3FF, 10'h0F0, 32'h0);
        add(0, 0, 0, 10'h30F, 32'h30F);
        // TOGGLE and DATA writes coincident with a phase flip.
        add(1, 1, 32'h0FF, 10'h30F, 32'h0);
        add(1, 2, 32'd2, 10'h30F, 32'h0);
        add(0, 3, 0, 10'h30F, 32'h0);
        add(1, 3, 32'h00F, 10'h30F, 32'h0);
        add(0, 0, 0, 10'h3FF, 32'h300);
        add(0, 3, 0, 10'h3FF, 32'h1);
        add(0, 0, 0, 10'h300, 32'h300);
        add(1, 0, 32'h005, 10'h300, 32'h300);
        add(0, 1, 0, 10'h0FA, 32'h0FF);
        // Full 32-bit PERIOD readback.
        add(1, 2, 32'h80000000, 10'h0FA, 32'd2);
        add(0, 2, 0, 10'h005, 32'h80000000);

        // Reset state while held.
        #12;
        check_led("reset_hold", 0, 10'h000);
        check_rd("reset_hold", 0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // No writes: outputs and phase stay 0.
        for (int i = 0; i < 20; i++)
            apply("idle", i, 1'b0, 2'd3, 32'h0, 10'h000, 32'h0);

        for (int i = 0; i < vecs.size(); i++)
            apply("vec", i, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp_led, vecs[i].exp_rd);

        // Async reset mid-blink (DATA=5, MASK=0xFF).
        apply("arst_pre", 0, 1'b1, 2'd2, 32'd2, 10'h005, 32'h80000000);
        apply("arst_pre", 1, 1'b0, 2'd3, 32'h0, 10'h005, 32'h0);
        apply("arst_pre", 2, 1'b0, 2'd3, 32'h0, 10'h005, 32'h0);
        apply("arst_pre", 3, 1'b0, 2'd3, 32'h0, 10'h0FA, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_led("arst_now", 0, 10'h000);
        check_rd("arst_now", 0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        apply("arst_post", 0, 1'b0, 2'd0, 32'h0, 10'h000, 32'h0);
        apply("arst_post", 1, 1'b0, 2'd1, 32'h0, 10'h000, 32'h0);
        apply("arst_post", 2, 1'b0, 2'd2, 32'h0, 10'h000, 32'h0);
        apply("arst_post", 3, 1'b0, 2'd3, 32'h0, 10'h000, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
